// File: rtl/ysyx_lsu.sv
`default_nettype none
// ============================================================================
// ysyx_lsu : single-outstanding load/store unit between EXU and a memory port
// Optional: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word ops.
// Revision: 1.0
// ============================================================================
module ysyx_lsu #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    logic [1:0]       r_state;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic             w_legal;
    logic             w_misalign;
    logic [1:0]       w_off;
    logic [31:0]      w_shifted;
    logic [31:0]      w_load_data;
    logic [3:0]       w_wmask;
    logic [CNT_W:0]   w_cnt_next;
    logic             w_timeout;

    assign w_off = r_addr[1:0];

    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_is_store;
            default:                w_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = (req_addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Bytes beyond the top lane shift in as zero, which covers misaligned loads.
    assign w_shifted = mem_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_wmask = 4'b0000;
        if (r_is_store) begin
            case (r_funct3)
                3'b000:  w_wmask = 4'b0001 << w_off;
                3'b001:  w_wmask = 4'b0011 << w_off;
                default: w_wmask = 4'b1111;
            endcase
        end
    end

    // One extra bit so the compare still fires if the count passed the limit
    // on the same cycle the request handshake won priority.
    assign w_cnt_next = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_timeout  = (TIMEOUT_CYC != 0) && (w_cnt_next >= (CNT_W+1)'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_cnt      <= '0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_is_store <= req_is_store;
                        r_funct3   <= req_funct3;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_cnt      <= '0;
                        r_rdata    <= 32'h0;
                        if (!w_legal || w_misalign) begin
                            r_err   <= 1'b1;
                            r_state <= c_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= c_REQ;
                        end
                    end
                end
                c_REQ: begin
                    r_cnt <= w_cnt_next[CNT_W-1:0];
                    if (mem_req_ready) begin
                        r_state <= c_WAIT;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                        r_state <= c_RESP;
                    end
                end
                c_WAIT: begin
                    r_cnt <= w_cnt_next[CNT_W-1:0];
                    if (mem_rsp_valid) begin
                        r_err   <= 1'b0;
                        r_rdata <= r_is_store ? 32'h0 : w_load_data;
                        r_state <= c_RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                        r_state <= c_RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready     = (r_state == c_IDLE);
    assign mem_req_valid = (r_state == c_REQ);
    assign mem_wen       = r_is_store;
    assign mem_addr      = {r_addr[31:2], 2'b00};
    assign mem_wdata     = r_wdata << {w_off, 3'b000};
    assign mem_wmask     = w_wmask;
    assign rsp_valid     = (r_state == c_RESP);
    assign rsp_rdata     = r_rdata;
    assign rsp_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_lsu.sv
`default_nettype none
// ============================================================================
// tb_ysyx_lsu : directed self-checking bench for ysyx_lsu (TIMEOUT_CYC = 4)
// Revision: 1.0
// ============================================================================
module tb_ysyx_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_lsu #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one cycle; DUT is in IDLE so it is accepted.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        step();
        req_valid    = 1'b0;
    endtask

    // Zero-wait memory: handshake in REQ, response in the first WAIT cycle.
    task automatic mem_zero_wait(input logic [31:0] rd);
        chk("req_valid_T+1", 32'(mem_req_valid), 32'h1);
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd;
        step();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic rsp_done();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        mem_rdata = 32'h0; rsp_ready = 1'b0;
        step(); step();
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        step();

        // LW with one memory wait cycle
        issue(1'b0, 3'b010, 32'h8000_0004, 32'h0);
        chk("lw_mem_req_valid", 32'(mem_req_valid), 32'h1);
        chk("lw_mem_addr", mem_addr, 32'h8000_0004);
        chk("lw_wmask", 32'(mem_wmask), 32'h0);
        chk("lw_wen", 32'(mem_wen), 32'h0);
        step();
        chk("lw_wait_no_req", 32'(mem_req_valid), 32'h0);
        step();
        chk("lw_wait_no_rsp", 32'(rsp_valid), 32'h0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rsp_valid = 1'b0;
        chk("lw_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("lw_err", 32'(rsp_err), 32'h0);
        rsp_done();
        chk("lw_back_idle", 32'(req_ready), 32'h1);

        // LB / LBU / LHU formatting
        issue(1'b0, 3'b000, 32'h8000_0003, 32'h0);
        mem_zero_wait(32'h8011_2233);
        chk("lb_rsp_valid_T+3", 32'(rsp_valid), 32'h1);
        chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
        rsp_done();
        issue(1'b0, 3'b100, 32'h8000_0003, 32'h0);
        mem_zero_wait(32'h8011_2233);
        chk("lbu_rdata", rsp_rdata, 32'h0000_0080);
        rsp_done();
        issue(1'b0, 3'b101, 32'h8000_0002, 32'h0);
        mem_zero_wait(32'h8011_2233);
        chk("lhu_rdata", rsp_rdata, 32'h0000_8011);
        rsp_done();
        issue(1'b0, 3'b001, 32'h8000_0000, 32'h0);
        mem_zero_wait(32'h1234_9ABC);
        chk("lh_rdata", rsp_rdata, 32'hFFFF_9ABC);
        rsp_done();

        // SH and SB lane placement
        issue(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD);
        chk("sh_wen", 32'(mem_wen), 32'h1);
        chk("sh_wmask", 32'(mem_wmask), 32'hC);
        chk("sh_wdata", mem_wdata, 32'hABCD_0000);
        chk("sh_addr", mem_addr, 32'h8000_0000);
        mem_zero_wait(32'h5555_5555);
        chk("sh_rdata", rsp_rdata, 32'h0);
        chk("sh_err", 32'(rsp_err), 32'h0);
        rsp_done();
        issue(1'b1, 3'b000, 32'h8000_0001, 32'h0000_0012);
        chk("sb_wmask", 32'(mem_wmask), 32'h2);
        chk("sb_wdata", mem_wdata, 32'h0000_1200);
        mem_zero_wait(32'h0);
        rsp_done();

        // Illegal funct3: load 011 and store 100
        issue(1'b0, 3'b011, 32'h8000_0000, 32'h0);
        chk("ill_no_mem_req", 32'(mem_req_valid), 32'h0);
        chk("ill_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ill_err", 32'(rsp_err), 32'h1);
        chk("ill_rdata", rsp_rdata, 32'h0);
        rsp_done();
        issue(1'b1, 3'b100, 32'h8000_0000, 32'h0);
        chk("ill_st_err", 32'(rsp_err), 32'h1);
        chk("ill_st_rsp_valid", 32'(rsp_valid), 32'h1);
        rsp_done();

        // Misaligned LW
        issue(1'b0, 3'b010, 32'h8000_0002, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis_no_mem_req", 32'(mem_req_valid), 32'h0);
        chk("mis_err", 32'(rsp_err), 32'h1);
        chk("mis_rsp_valid", 32'(rsp_valid), 32'h1);
`else
        mem_zero_wait(32'h1122_3344);
        chk("mis_rdata", rsp_rdata, 32'h0000_1122);
        chk("mis_err", 32'(rsp_err), 32'h0);
`endif
        rsp_done();

        // Timeout with mem_req_ready held low, then response back-pressure
        mem_req_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h8000_0008, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("to_req_held", 32'(mem_req_valid), 32'h1);
            chk("to_no_rsp_yet", 32'(rsp_valid), 32'h0);
            step();
        end
        chk("to_req_last", 32'(mem_req_valid), 32'h1);
        step();
        chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("to_err", 32'(rsp_err), 32'h1);
        chk("to_rdata", rsp_rdata, 32'h0);
        chk("to_req_dropped", 32'(mem_req_valid), 32'h0);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("hold_err", 32'(rsp_err), 32'h1);
        end
        rsp_done();

        // Data stability under back-pressure for a real load
        issue(1'b0, 3'b010, 32'h8000_000C, 32'h0);
        mem_zero_wait(32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_ld_valid", 32'(rsp_valid), 32'h1);
            chk("hold_ld_rdata", rsp_rdata, 32'hCAFE_F00D);
        end
        rsp_done();

        // Reset while in WAIT, then a stale response
        issue(1'b0, 3'b010, 32'h8000_0010, 32'h0);
        step();
        chk("rw_in_wait", 32'(mem_req_valid), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_req_ready", 32'(req_ready), 32'h1);
        chk("rw_mem_req_valid", 32'(mem_req_valid), 32'h0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        mem_rsp_valid = 1'b0;
        chk("rw_no_rsp", 32'(rsp_valid), 32'h0);
        step();
        chk("rw_no_rsp2", 32'(rsp_valid), 32'h0);
        chk("rw_idle", 32'(req_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
